// File: rtl/logic_resp_checker.sv
// Response checker for the 4-bit bitwise logic gates: recomputes the expected result,
// counts passes/fails, captures the first mismatch and folds every result into a MISR.
module logic_resp_checker #(
    parameter int unsigned      WIDTH = 4,
    parameter int unsigned      CNT_W = 8,
    parameter logic [WIDTH-1:0] POLY  = 4'b0011
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_i,
    input  logic [1:0]       op_sel_i,
    input  logic [CNT_W-1:0] num_vectors_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic [WIDTH-1:0] result_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [CNT_W-1:0] pass_cnt_o,
    output logic [CNT_W-1:0] fail_cnt_o,
    output logic             first_fail_valid_o,
    output logic [CNT_W-1:0] first_fail_idx_o,
    output logic [WIDTH-1:0] first_fail_exp_o,
    output logic [WIDTH-1:0] first_fail_got_o,
    output logic [WIDTH-1:0] sig_o
);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e           state_q, state_d;
    logic [1:0]       op_q, op_d;
    logic [CNT_W-1:0] num_q, num_d;
    logic [CNT_W-1:0] idx_q, idx_d;
    logic [CNT_W-1:0] pass_q, pass_d;
    logic [CNT_W-1:0] fail_q, fail_d;
    logic             ff_valid_q, ff_valid_d;
    logic [CNT_W-1:0] ff_idx_q, ff_idx_d;
    logic [WIDTH-1:0] ff_exp_q, ff_exp_d;
    logic [WIDTH-1:0] ff_got_q, ff_got_d;
    logic [WIDTH-1:0] sig_q, sig_d;

    logic [WIDTH-1:0] exp_w;
    logic [CNT_W:0]   acc_cnt;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == '1) ? v : v + CNT_W'(1);
    endfunction

    always_comb begin
        case (op_q)
            2'b00:   exp_w = a_i & b_i;
            2'b01:   exp_w = a_i | b_i;
            2'b10:   exp_w = a_i ^ b_i;
            default: exp_w = ~a_i;
        endcase
    end

    // Extra bit keeps the accepted-count compare free of wrap at the counter limit.
    assign acc_cnt = {1'b0, idx_q} + (CNT_W + 1)'(1);

    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        num_d      = num_q;
        idx_d      = idx_q;
        pass_d     = pass_q;
        fail_d     = fail_q;
        ff_valid_d = ff_valid_q;
        ff_idx_d   = ff_idx_q;
        ff_exp_d   = ff_exp_q;
        ff_got_d   = ff_got_q;
        sig_d      = sig_q;
        case (state_q)
            StIdle, StDone: begin
                if (start_i) begin
                    op_d       = op_sel_i;
                    num_d      = num_vectors_i;
                    idx_d      = '0;
                    pass_d     = '0;
                    fail_d     = '0;
                    ff_valid_d = 1'b0;
                    ff_idx_d   = '0;
                    ff_exp_d   = '0;
                    ff_got_d   = '0;
                    sig_d      = '0;
                    state_d    = (num_vectors_i == '0) ? StDone : StRun;
                end
            end
            StRun: begin
                if (in_valid_i) begin
                    if (result_i == exp_w) begin
                        pass_d = sat_inc(pass_q);
                    end else begin
                        fail_d = sat_inc(fail_q);
                        if (!ff_valid_q) begin
                            ff_valid_d = 1'b1;
                            ff_idx_d   = idx_q;
                            ff_exp_d   = exp_w;
                            ff_got_d   = result_i;
                        end
                    end
                    sig_d = ({sig_q[WIDTH-2:0], 1'b0} ^ (sig_q[WIDTH-1] ? POLY : '0)) ^ result_i;
                    idx_d = acc_cnt[CNT_W-1:0];
                    if (acc_cnt >= {1'b0, num_q}) begin
                        state_d = StDone;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            op_q       <= '0;
            num_q      <= '0;
            idx_q      <= '0;
            pass_q     <= '0;
            fail_q     <= '0;
            ff_valid_q <= 1'b0;
            ff_idx_q   <= '0;
            ff_exp_q   <= '0;
            ff_got_q   <= '0;
            sig_q      <= '0;
        end else begin
            state_q    <= state_d;
            op_q       <= op_d;
            num_q      <= num_d;
            idx_q      <= idx_d;
            pass_q     <= pass_d;
            fail_q     <= fail_d;
            ff_valid_q <= ff_valid_d;
            ff_idx_q   <= ff_idx_d;
            ff_exp_q   <= ff_exp_d;
            ff_got_q   <= ff_got_d;
            sig_q      <= sig_d;
        end
    end

    assign in_ready_o         = (state_q == StRun);
    assign busy_o             = (state_q == StRun);
    assign done_o             = (state_q == StDone);
    assign pass_cnt_o         = pass_q;
    assign fail_cnt_o         = fail_q;
    assign first_fail_valid_o = ff_valid_q;
    assign first_fail_idx_o   = ff_idx_q;
    assign first_fail_exp_o   = ff_exp_q;
    assign first_fail_got_o   = ff_got_q;
    assign sig_o              = sig_q;

endmodule

// File: tb/tb_logic_resp_checker.sv
// Scoreboard bench for logic_resp_checker: a behavioural model predicts each accepted
// vector's outcome, and a monitor compares it against the DUT after every acceptance.
module tb_logic_resp_checker;

    localparam int W  = 4;
    localparam int CW = 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [1:0]    op_sel = '0;
    logic [CW-1:0] num_vectors = '0;
    logic          in_valid = 1'b0;
    logic [W-1:0]  a = '0, b = '0, result = '0;
    logic          in_ready, busy, done, ffv;
    logic [CW-1:0] pass_cnt, fail_cnt, ff_idx;
    logic [W-1:0]  ff_exp, ff_got, sig;

    logic_resp_checker #(.WIDTH(W), .CNT_W(CW), .POLY(4'b0011)) dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .start_i            (start),
        .op_sel_i           (op_sel),
        .num_vectors_i      (num_vectors),
        .in_valid_i         (in_valid),
        .in_ready_o         (in_ready),
        .a_i                (a),
        .b_i                (b),
        .result_i           (result),
        .busy_o             (busy),
        .done_o             (done),
        .pass_cnt_o         (pass_cnt),
        .fail_cnt_o         (fail_cnt),
        .first_fail_valid_o (ffv),
        .first_fail_idx_o   (ff_idx),
        .first_fail_exp_o   (ff_exp),
        .first_fail_got_o   (ff_got),
        .sig_o              (sig)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [CW-1:0] pass;
        logic [CW-1:0] fail;
        logic          ffv;
        logic [CW-1:0] ffidx;
        logic [W-1:0]  ffexp;
        logic [W-1:0]  ffgot;
        logic [W-1:0]  sig;
        logic          done;
    } rec_t;

    rec_t exp_q[$];
    int   total = 0;
    int   bad = 0;

    // Reference model state
    bit            m_run = 0, m_done = 0;
    logic [1:0]    m_op = 0;
    int            m_num = 0, m_cnt = 0, m_pass = 0, m_fail = 0;
    bit            m_ffv = 0;
    int            m_ffidx = 0;
    logic [W-1:0]  m_ffexp = 0, m_ffgot = 0, m_sig = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h at %0t", name, got, want, $time);
        end
    endtask

    function automatic logic [W-1:0] ref_exp(input logic [1:0] op, input logic [W-1:0] x,
                                             input logic [W-1:0] y);
        case (op)
            2'd0:    return x & y;
            2'd1:    return x | y;
            2'd2:    return x ^ y;
            default: return ~x;
        endcase
    endfunction

    // Signature as polynomial arithmetic: sig*x mod (x^4+x+1), plus the new result.
    function automatic logic [W-1:0] ref_misr(input logic [W-1:0] s, input logic [W-1:0] r);
        logic [W:0] t;
        t = {s, 1'b0};
        if (t[W]) t = t ^ 5'b10011;
        return t[W-1:0] ^ r;
    endfunction

    task automatic model_clear();
        m_cnt = 0; m_pass = 0; m_fail = 0; m_ffv = 0; m_ffidx = 0;
        m_ffexp = '0; m_ffgot = '0; m_sig = '0;
    endtask

    task automatic model_accept(input logic [W-1:0] x, input logic [W-1:0] y,
                                input logic [W-1:0] r);
        logic [W-1:0] e;
        rec_t rec;
        e = ref_exp(m_op, x, y);
        if (r == e) m_pass++;
        else begin
            m_fail++;
            if (!m_ffv) begin
                m_ffv = 1; m_ffidx = m_cnt; m_ffexp = e; m_ffgot = r;
            end
        end
        m_sig = ref_misr(m_sig, r);
        m_cnt++;
        if (m_cnt == m_num) begin
            m_run = 0; m_done = 1;
        end
        rec.pass = CW'(m_pass); rec.fail = CW'(m_fail); rec.ffv = m_ffv;
        rec.ffidx = CW'(m_ffidx); rec.ffexp = m_ffexp; rec.ffgot = m_ffgot;
        rec.sig = m_sig; rec.done = m_done;
        exp_q.push_back(rec);
    endtask

    task automatic check_all(input string tag);
        check({tag, "_pass"}, 32'(pass_cnt), 32'(m_pass));
        check({tag, "_fail"}, 32'(fail_cnt), 32'(m_fail));
        check({tag, "_ffv"}, 32'(ffv), 32'(m_ffv));
        check({tag, "_ffidx"}, 32'(ff_idx), 32'(m_ffidx));
        check({tag, "_ffexp"}, 32'(ff_exp), 32'(m_ffexp));
        check({tag, "_ffgot"}, 32'(ff_got), 32'(m_ffgot));
        check({tag, "_sig"}, 32'(sig), 32'(m_sig));
    endtask

    // One clock of stimulus; the model is advanced from its own pre-edge state.
    task automatic cycle(input logic st, input logic [1:0] op, input int n, input logic v,
                         input logic [W-1:0] x, input logic [W-1:0] y, input logic [W-1:0] r);
        bit started;
        started = 0;
        @(negedge clk);
        start = st; op_sel = op; num_vectors = CW'(n); in_valid = v;
        a = x; b = y; result = r;
        if (m_run) begin
            if (v) model_accept(x, y, r);
        end else if (st) begin
            m_op = op; m_num = n; model_clear();
            m_run = (n != 0); m_done = (n == 0);
            started = 1;
        end
        @(posedge clk);
        #1;
        check("busy", 32'(busy), 32'(m_run));
        check("done", 32'(done), 32'(m_done));
        check("in_ready", 32'(in_ready), 32'(m_run));
        if (started) check_all("start");
    endtask

    task automatic idle_cycle();
        cycle(1'b0, 2'd0, 0, 1'b0, '0, '0, '0);
    endtask

    // Monitor: every DUT acceptance pops one predicted record.
    always @(posedge clk) begin
        if (in_valid && in_ready) begin
            rec_t r;
            #1;
            if (exp_q.size() == 0) begin
                check("unexpected_accept", 32'd1, 32'd0);
            end else begin
                r = exp_q.pop_front();
                check("sb_pass", 32'(pass_cnt), 32'(r.pass));
                check("sb_fail", 32'(fail_cnt), 32'(r.fail));
                check("sb_ffv", 32'(ffv), 32'(r.ffv));
                check("sb_ffidx", 32'(ff_idx), 32'(r.ffidx));
                check("sb_ffexp", 32'(ff_exp), 32'(r.ffexp));
                check("sb_ffgot", 32'(ff_got), 32'(r.ffgot));
                check("sb_sig", 32'(sig), 32'(r.sig));
                check("sb_done", 32'(done), 32'(r.done));
            end
        end
    end

    initial begin
        repeat (2) @(negedge clk);
        check_all("reset");
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_done", 32'(done), 32'd0);
        check("reset_ready", 32'(in_ready), 32'd0);
        rst_n = 1'b1;

        // OR, two passing vectors; start+in_valid together must not accept
        cycle(1'b1, 2'd1, 2, 1'b1, 4'b1110, 4'b0100, 4'b1110);
        cycle(1'b0, 2'd1, 2, 1'b1, 4'b1110, 4'b0100, 4'b1110);
        cycle(1'b0, 2'd1, 2, 1'b1, 4'b1111, 4'b1010, 4'b1111);
        check("or_sig", 32'(sig), 32'h0);
        check("or_pass", 32'(pass_cnt), 32'd2);

        // OR with mismatches; the second must not overwrite the capture
        cycle(1'b1, 2'd1, 3, 1'b0, '0, '0, '0);
        cycle(1'b0, 2'd1, 0, 1'b1, 4'b1110, 4'b0100, 4'b1100);
        cycle(1'b0, 2'd1, 0, 1'b1, 4'b1111, 4'b1010, 4'b1111);
        cycle(1'b0, 2'd1, 0, 1'b1, 4'b0000, 4'b0001, 4'b0000);
        check("mm_idx", 32'(ff_idx), 32'd0);
        check("mm_exp", 32'(ff_exp), 32'b1110);
        check("mm_got", 32'(ff_got), 32'b1100);

        // Each op with a=1100 b=1010; NOT sees b=1111
        for (int op = 0; op < 4; op++) begin
            logic [W-1:0] golden[4];
            golden = '{4'b1000, 4'b1110, 4'b0110, 4'b0011};
            cycle(1'b1, 2'(op), 1, 1'b0, '0, '0, '0);
            cycle(1'b0, 2'(op), 0, 1'b1, 4'b1100, (op == 3) ? 4'b1111 : 4'b1010, golden[op]);
            check("op_pass", 32'(pass_cnt), 32'd1);
        end

        // in_valid gaps, then in_valid in DONE
        cycle(1'b1, 2'd2, 2, 1'b0, '0, '0, '0);
        cycle(1'b0, 2'd2, 0, 1'b1, 4'b0101, 4'b0011, 4'b0110);
        cycle(1'b0, 2'd2, 0, 1'b0, 4'b1111, 4'b1111, 4'b1111);
        cycle(1'b0, 2'd2, 0, 1'b1, 4'b1001, 4'b0011, 4'b1010);
        cycle(1'b0, 2'd2, 0, 1'b1, 4'b1001, 4'b0011, 4'b0000);
        cycle(1'b0, 2'd2, 0, 1'b1, 4'b1001, 4'b0011, 4'b0000);
        check_all("done_hold");

        // num_vectors=0, then restart with one vector
        cycle(1'b1, 2'd0, 0, 1'b0, '0, '0, '0);
        check("zero_done", 32'(done), 32'd1);
        cycle(1'b1, 2'd0, 1, 1'b0, '0, '0, '0);
        cycle(1'b0, 2'd0, 0, 1'b1, 4'b0111, 4'b1101, 4'b0001);

        // Reset mid-run after one of three vectors
        cycle(1'b1, 2'd2, 3, 1'b0, '0, '0, '0);
        cycle(1'b0, 2'd2, 0, 1'b1, 4'b0110, 4'b0011, 4'b0100);
        @(negedge clk);
        in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        m_run = 0; m_done = 0; model_clear();
        check_all("abort");
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        check("abort_ready", 32'(in_ready), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Randomised runs, with ignored start pulses during RUN
        for (int run = 0; run < 25; run++) begin
            int budget;
            cycle(1'b1, 2'($urandom_range(0, 3)), $urandom_range(0, 12), 1'b0, '0, '0, '0);
            budget = 0;
            while (m_run && budget < 200) begin
                logic [W-1:0] x, y, r;
                x = 4'($urandom);
                y = 4'($urandom);
                r = ($urandom_range(0, 9) < 7) ? ref_exp(m_op, x, y) : 4'($urandom);
                cycle(($urandom_range(0, 9) == 0), 2'($urandom_range(0, 3)),
                      $urandom_range(0, 12), ($urandom_range(0, 9) < 7), x, y, r);
                budget++;
            end
            if (m_run) check("run_timeout", 32'd1, 32'd0);
            cycle(1'b0, 2'd0, 0, 1'b1, 4'($urandom), 4'($urandom), 4'($urandom));
            check_all("rand_end");
        end

        idle_cycle();
        check("queue_drain", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
